control_sequencer: RTL and testbench

Microcoded control unit for the 8-bit bus CPU. Steps through fetch and execute micro-steps, decodes the instruction register (IR) opcode, and drives every datapath load and drive strobe: PC, MAR, RAM, IR, A, B, ALU and output register. Holds the carry and zero flags used for conditional jumps. Sits directly upstream of the datapath; its outputs are the control word the datapath consumes.

---
 rtl/control_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_control_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// control_sequencer: microcoded control unit for the 8-bit bus CPU.
//
// Steps T0..T4 (T5 unreachable), decodes the opcode in ir[7:4] and drives
// the datapath strobes combinationally. The fetch steps (T0, T1) are common
// to all instructions. HLT latches a halted state that only rst clears.
//
// Optional feature: define CONDITIONAL_JUMP_EN to build the carry/zero flag
// registers and the JC/JZ instructions. Without it, opcodes 7 and 8 run as
// NOP and carry_flag/zero_flag read 0.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   step_en                  1 = advance, 0 = stall (step/flags hold, strobes 0)
//   ir[7:0]                  instruction register contents
//   alu_carry, alu_zero      ALU status, latched at the end of T4 of ADD/SUB
//   pc_in/pc_out/pc_add      PC load / drive bus / increment
//   mar_in                   MAR load
//   ram_in/ram_out           RAM write / drive bus
//   ir_in/ir_out             IR load / drive ir[3:0] onto bus
//   a_in/a_out, b_in/b_out   register load / drive
//   alu_out/alu_sub          ALU drive bus / subtract select
//   output_in                output register load
//   hlt                      halted indicator
//   carry_flag, zero_flag    latched flags
//   step[2:0]                current micro-step
module control_sequencer (
  input  logic       clk,
  input  logic       rst,
  input  logic       step_en,
  input  logic [7:0] ir,
  input  logic       alu_carry,
  input  logic       alu_zero,
  output logic       pc_in,
  output logic       pc_out,
  output logic       pc_add,
  output logic       mar_in,
  output logic       ram_in,
  output logic       ram_out,
  output logic       ir_in,
  output logic       ir_out,
  output logic       a_in,
  output logic       a_out,
  output logic       b_in,
  output logic       b_out,
  output logic       alu_out,
  output logic       alu_sub,
  output logic       output_in,
  output logic       hlt,
  output logic       carry_flag,
  output logic       zero_flag,
  output logic [2:0] step
);

  typedef enum logic [2:0] {
    StT0 = 3'd0,
    StT1 = 3'd1,
    StT2 = 3'd2,
    StT3 = 3'd3,
    StT4 = 3'd4,
    StT5 = 3'd5
  } step_e;

  localparam logic [3:0] OpNop = 4'h0;
  localparam logic [3:0] OpLda = 4'h1;
  localparam logic [3:0] OpAdd = 4'h2;
  localparam logic [3:0] OpSub = 4'h3;
  localparam logic [3:0] OpSta = 4'h4;
  localparam logic [3:0] OpLdi = 4'h5;
  localparam logic [3:0] OpJmp = 4'h6;
  localparam logic [3:0] OpJc  = 4'h7;
  localparam logic [3:0] OpJz  = 4'h8;
  localparam logic [3:0] OpOut = 4'hE;
  localparam logic [3:0] OpHlt = 4'hF;

  step_e      step_q;
  logic       halted_q;
  logic       carry_q;
  logic       zero_q;
  logic [3:0] opcode;
  logic       run;

  assign opcode = ir[7:4];
  // Strobes are live only when running, not halted and not in reset.
  assign run    = step_en && !halted_q && !rst;

  // The operand nibble goes to the bus through the datapath, not through here.
  logic unused_operand;
  assign unused_operand = ^ir[3:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      step_q   <= StT0;
      halted_q <= 1'b0;
`ifdef CONDITIONAL_JUMP_EN
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
`endif
    end else if (step_en && !halted_q) begin
      case (step_q)
        StT0: step_q <= StT1;
        StT1: step_q <= StT2;
        StT2: begin
          if (opcode == OpHlt) begin
            // Stay at T2 with the halted latch set.
            halted_q <= 1'b1;
          end else if (opcode == OpLda || opcode == OpAdd ||
                       opcode == OpSub || opcode == OpSta) begin
            step_q <= StT3;
          end else begin
            step_q <= StT0;
          end
        end
        StT3: begin
          if (opcode == OpAdd || opcode == OpSub) step_q <= StT4;
          else                                    step_q <= StT0;
        end
        StT4: begin
          step_q <= StT0;
`ifdef CONDITIONAL_JUMP_EN
          if (opcode == OpAdd || opcode == OpSub) begin
            carry_q <= alu_carry;
            zero_q  <= alu_zero;
          end
`endif
        end
        default: step_q <= StT0;
      endcase
    end
  end

`ifndef CONDITIONAL_JUMP_EN
  assign carry_q = 1'b0;
  assign zero_q  = 1'b0;
  logic unused_alu_flags;
  assign unused_alu_flags = alu_carry ^ alu_zero;
`endif

  always_comb begin
    pc_in     = 1'b0;
    pc_out    = 1'b0;
    pc_add    = 1'b0;
    mar_in    = 1'b0;
    ram_in    = 1'b0;
    ram_out   = 1'b0;
    ir_in     = 1'b0;
    ir_out    = 1'b0;
    a_in      = 1'b0;
    a_out     = 1'b0;
    b_in      = 1'b0;
    b_out     = 1'b0;
    alu_out   = 1'b0;
    alu_sub   = 1'b0;
    output_in = 1'b0;
    if (run) begin
      case (step_q)
        StT0: begin
          pc_out = 1'b1;
          mar_in = 1'b1;
        end
        StT1: begin
          ram_out = 1'b1;
          ir_in   = 1'b1;
          pc_add  = 1'b1;
        end
        StT2: begin
          case (opcode)
            OpLda, OpAdd, OpSub, OpSta: begin
              ir_out = 1'b1;
              mar_in = 1'b1;
            end
            OpLdi: begin
              ir_out = 1'b1;
              a_in   = 1'b1;
            end
            OpJmp: begin
              ir_out = 1'b1;
              pc_in  = 1'b1;
            end
`ifdef CONDITIONAL_JUMP_EN
            OpJc: begin
              ir_out = carry_q;
              pc_in  = carry_q;
            end
            OpJz: begin
              ir_out = zero_q;
              pc_in  = zero_q;
            end
`endif
            OpOut: begin
              a_out     = 1'b1;
              output_in = 1'b1;
            end
            default: ;  // NOP, HLT, undefined opcodes
          endcase
        end
        StT3: begin
          case (opcode)
            OpLda: begin
              ram_out = 1'b1;
              a_in    = 1'b1;
            end
            OpAdd, OpSub: begin
              ram_out = 1'b1;
              b_in    = 1'b1;
            end
            OpSta: begin
              a_out  = 1'b1;
              ram_in = 1'b1;
            end
            default: ;
          endcase
        end
        StT4: begin
          if (opcode == OpAdd || opcode == OpSub) begin
            alu_out = 1'b1;
            a_in    = 1'b1;
            alu_sub = (opcode == OpSub);
          end
        end
        default: ;  // T5: no strobes
      endcase
    end
  end

  logic unused_nop;
  assign unused_nop = (opcode == OpNop) && (opcode == OpJc) && (opcode == OpJz);

  assign hlt        = halted_q;
  assign carry_flag = carry_q;
  assign zero_flag  = zero_q;
  assign step       = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

`ifdef CONDITIONAL_JUMP_EN
  localparam bit CJ = 1'b1;
`else
  localparam bit CJ = 1'b0;
`endif

  // Strobe bit positions in the packed control word.
  localparam logic [14:0] S_PC_IN   = 15'h4000;
  localparam logic [14:0] S_PC_OUT  = 15'h2000;
  localparam logic [14:0] S_PC_ADD  = 15'h1000;
  localparam logic [14:0] S_MAR_IN  = 15'h0800;
  localparam logic [14:0] S_RAM_IN  = 15'h0400;
  localparam logic [14:0] S_RAM_OUT = 15'h0200;
  localparam logic [14:0] S_IR_IN   = 15'h0100;
  localparam logic [14:0] S_IR_OUT  = 15'h0080;
  localparam logic [14:0] S_A_IN    = 15'h0040;
  localparam logic [14:0] S_A_OUT   = 15'h0020;
  localparam logic [14:0] S_B_IN    = 15'h0010;
  localparam logic [14:0] S_B_OUT   = 15'h0008;
  localparam logic [14:0] S_ALU_OUT = 15'h0004;
  localparam logic [14:0] S_ALU_SUB = 15'h0002;
  localparam logic [14:0] S_OUT_IN  = 15'h0001;
  localparam logic [14:0] S_NONE    = 15'h0000;

  logic       clk = 1'b0;
  logic       rst, step_en, alu_carry, alu_zero;
  logic [7:0] ir;
  logic pc_in, pc_out, pc_add, mar_in, ram_in, ram_out, ir_in, ir_out;
  logic a_in, a_out, b_in, b_out, alu_out, alu_sub, output_in;
  logic hlt, carry_flag, zero_flag;
  logic [2:0] step;

  control_sequencer dut (
    .clk(clk), .rst(rst), .step_en(step_en), .ir(ir),
    .alu_carry(alu_carry), .alu_zero(alu_zero),
    .pc_in(pc_in), .pc_out(pc_out), .pc_add(pc_add), .mar_in(mar_in),
    .ram_in(ram_in), .ram_out(ram_out), .ir_in(ir_in), .ir_out(ir_out),
    .a_in(a_in), .a_out(a_out), .b_in(b_in), .b_out(b_out),
    .alu_out(alu_out), .alu_sub(alu_sub), .output_in(output_in),
    .hlt(hlt), .carry_flag(carry_flag), .zero_flag(zero_flag), .step(step)
  );

  always #5 clk = ~clk;

  logic [20:0] obs;
  assign obs = {pc_in, pc_out, pc_add, mar_in, ram_in, ram_out, ir_in, ir_out,
                a_in, a_out, b_in, b_out, alu_out, alu_sub, output_in,
                hlt, carry_flag, zero_flag, step};

  typedef struct {
    string       tag;
    logic [20:0] w;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  logic cf = 1'b0;  // model of carry_flag
  logic zf = 1'b0;  // model of zero_flag

  function automatic logic [20:0] mk(logic [14:0] s, logic h, logic [2:0] st);
    return {s, h, cf, zf, st};
  endfunction

  task automatic push(input string tag, input logic [20:0] w);
    exp_t e;
    e.tag = tag;
    e.w   = w;
    q.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    e = q.pop_front();
    n_cmp++;
    assert (obs === e.w) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", e.tag, obs, e.w);
    end
    n_cmp++;
    assert ($countones({pc_out, ram_out, ir_out, a_out, b_out, alu_out}) <= 1) else begin
      n_bad++;
      $error("FAIL %s_bus: observed %0d drivers expected at most 1", e.tag,
             $countones({pc_out, ram_out, ir_out, a_out, b_out, alu_out}));
    end
  endtask

  // One full cycle: expectation queued now, checked at the falling edge.
  task automatic cyc(input string tag, input logic [20:0] w);
    push(tag, w);
    @(negedge clk);
    pop_compare();
    @(posedge clk);
    #1;
  endtask

  // Immediate check without advancing the clock.
  task automatic check_now(input string tag, input logic [20:0] w);
    push(tag, w);
    #1;
    pop_compare();
  endtask

  task automatic fetch(input string tag);
    cyc({tag, "_t0"}, mk(S_PC_OUT | S_MAR_IN, 1'b0, 3'd0));
    cyc({tag, "_t1"}, mk(S_RAM_OUT | S_IR_IN | S_PC_ADD, 1'b0, 3'd1));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; step_en = 1'b1; ir = 8'h00; alu_carry = 1'b0; alu_zero = 1'b0;
    check_now("reset", mk(S_NONE, 1'b0, 3'd0));
    @(posedge clk); #1;
    cyc("reset_hold", mk(S_NONE, 1'b0, 3'd0));
    rst = 1'b0;

    // LDA 0x1A
    ir = 8'h1A;
    fetch("lda");
    cyc("lda_t2", mk(S_IR_OUT | S_MAR_IN, 1'b0, 3'd2));
    cyc("lda_t3", mk(S_RAM_OUT | S_A_IN, 1'b0, 3'd3));

    // SUB with carry=1, zero=1 during T4
    ir = 8'h3B; alu_carry = 1'b1; alu_zero = 1'b1;
    fetch("sub");
    cyc("sub_t2", mk(S_IR_OUT | S_MAR_IN, 1'b0, 3'd2));
    cyc("sub_t3", mk(S_RAM_OUT | S_B_IN, 1'b0, 3'd3));
    cyc("sub_t4", mk(S_ALU_OUT | S_A_IN | S_ALU_SUB, 1'b0, 3'd4));
    cf = CJ; zf = CJ;

    // JC with carry_flag set
    ir = 8'h75; alu_carry = 1'b0; alu_zero = 1'b0;
    fetch("jc1");
    cyc("jc1_t2", mk((CJ && cf) ? (S_IR_OUT | S_PC_IN) : S_NONE, 1'b0, 3'd2));

    // LDA aborted by reset mid-T3
    ir = 8'h1A;
    fetch("lda_rst");
    cyc("lda_rst_t2", mk(S_IR_OUT | S_MAR_IN, 1'b0, 3'd2));
    check_now("lda_rst_t3", mk(S_RAM_OUT | S_A_IN, 1'b0, 3'd3));
    rst = 1'b1;
    cf = 1'b0; zf = 1'b0;
    check_now("mid_reset", mk(S_NONE, 1'b0, 3'd0));
    @(posedge clk); #1;
    cyc("mid_reset_hold", mk(S_NONE, 1'b0, 3'd0));
    rst = 1'b0;

    // JC with carry_flag clear
    ir = 8'h75;
    fetch("jc0");
    cyc("jc0_t2", mk(S_NONE, 1'b0, 3'd2));

    // ADD: carry 0, zero 1
    ir = 8'h2C; alu_carry = 1'b0; alu_zero = 1'b1;
    fetch("add");
    cyc("add_t2", mk(S_IR_OUT | S_MAR_IN, 1'b0, 3'd2));
    cyc("add_t3", mk(S_RAM_OUT | S_B_IN, 1'b0, 3'd3));
    cyc("add_t4", mk(S_ALU_OUT | S_A_IN, 1'b0, 3'd4));
    cf = 1'b0; zf = CJ;
    alu_zero = 1'b0;

    // JZ with zero_flag set
    ir = 8'h83;
    fetch("jz");
    cyc("jz_t2", mk((CJ && zf) ? (S_IR_OUT | S_PC_IN) : S_NONE, 1'b0, 3'd2));

    // STA with a 3-cycle stall in T3
    ir = 8'h4C;
    fetch("sta");
    cyc("sta_t2", mk(S_IR_OUT | S_MAR_IN, 1'b0, 3'd2));
    step_en = 1'b0;
    for (int i = 0; i < 3; i++) cyc("sta_stall", mk(S_NONE, 1'b0, 3'd3));
    step_en = 1'b1;
    cyc("sta_t3", mk(S_A_OUT | S_RAM_IN, 1'b0, 3'd3));

    // OUT, LDI, JMP, undefined, NOP
    ir = 8'hE0;
    fetch("out");
    cyc("out_t2", mk(S_A_OUT | S_OUT_IN, 1'b0, 3'd2));
    ir = 8'h57;
    fetch("ldi");
    cyc("ldi_t2", mk(S_IR_OUT | S_A_IN, 1'b0, 3'd2));
    ir = 8'h6F;
    fetch("jmp");
    cyc("jmp_t2", mk(S_IR_OUT | S_PC_IN, 1'b0, 3'd2));
    ir = 8'h9A;
    fetch("undef");
    cyc("undef_t2", mk(S_NONE, 1'b0, 3'd2));
    ir = 8'h00;
    fetch("nop");
    cyc("nop_t2", mk(S_NONE, 1'b0, 3'd2));

    // HLT then 20 halted cycles, then reset
    ir = 8'hF0;
    fetch("hlt");
    cyc("hlt_t2", mk(S_NONE, 1'b0, 3'd2));
    ir = 8'h1A;
    for (int i = 0; i < 20; i++) cyc("halted", mk(S_NONE, 1'b1, 3'd2));
    rst = 1'b1;
    cf = 1'b0; zf = 1'b0;
    check_now("hlt_reset", mk(S_NONE, 1'b0, 3'd0));
    @(posedge clk); #1;
    rst = 1'b0;
    cyc("post_reset_t0", mk(S_PC_OUT | S_MAR_IN, 1'b0, 3'd0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
